// File: rtl/parity_check_rx_pkg.sv
// Shared constants for the parity-checked serial receiver.
// State codes, parity sense and default counter width.
package parity_check_rx_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;

  localparam int ERR_CNT_WIDTH_DEF = 16;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/parity_err_counter.sv
// Saturating error counter; clear beats a same-cycle increment.
// Reusable by any link receiver that reports per-frame errors.
module parity_err_counter
  import parity_check_rx_pkg::*;
#(
  parameter int WIDTH = ERR_CNT_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/parity_check_rx.sv
// Deserializes LSB-first data plus one parity bit and flags
// parity errors; bad frames feed a saturating counter.
module parity_check_rx
  import parity_check_rx_pkg::*;
#(
  parameter int   INPUT_WIDTH   = 8,
  parameter logic ODD_PARITY    = EVEN,
  parameter int   ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               DigitSupply,
  input  logic                     serialIn,
  input  logic                     serialValid,
  input  logic                     syncClear,
  input  logic                     clearCount,
  output logic [INPUT_WIDTH-1:0]   outputData,
  output logic                     outputValid,
  output logic                     parityError,
  output logic [ERR_CNT_WIDTH-1:0] errorCount,
  output logic                     busy
);

  localparam int CW = $clog2(INPUT_WIDTH + 1);

  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic                   run_par;
  logic [INPUT_WIDTH-1:0] shreg;
  logic                   frame_done;
  logic                   frame_err;
  logic                   supply_unused;

  // Rails only pass through to cell instances; no logic role here.
  assign supply_unused = ^DigitSupply;

  assign frame_done = serialValid & ~syncClear & (state == PAR);
  assign frame_err  = run_par ^ serialIn ^ ODD_PARITY;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      run_par     <= 1'b0;
      shreg       <= '0;
      outputData  <= '0;
      outputValid <= 1'b0;
      parityError <= 1'b0;
    end else begin
      outputValid <= 1'b0;
      if (syncClear) begin
        state   <= IDLE;
        cnt     <= '0;
        run_par <= 1'b0;
        shreg   <= '0;
      end else if (serialValid) begin
        unique case (state)
          IDLE: begin
            shreg   <= INPUT_WIDTH'(serialIn);
            run_par <= serialIn;
            cnt     <= CW'(1);
            state   <= (INPUT_WIDTH == 1) ? PAR : DATA;
          end
          DATA: begin
            for (int i = 0; i < INPUT_WIDTH; i++) begin
              if (cnt == CW'(i)) shreg[i] <= serialIn;
            end
            run_par <= run_par ^ serialIn;
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(INPUT_WIDTH - 1)) state <= PAR;
          end
          PAR: begin
            state       <= IDLE;
            cnt         <= '0;
            run_par     <= 1'b0;
            outputData  <= shreg;
            parityError <= frame_err;
            outputValid <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  parity_err_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (frame_done & frame_err),
    .clr  (clearCount),
    .count(errorCount)
  );

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed bench: even/16-bit and odd/4-bit receivers share one
// serial stream; expected flags are hand-computed per frame.
module tb_parity_check_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] supply = 2'b10;
  logic       serialIn = 1'b0;
  logic       serialValid = 1'b0;
  logic       syncClear = 1'b0;
  logic       clearCount = 1'b0;

  logic [7:0]  d0, d1;
  logic        v0, v1, e0, e1, b0, b1;
  logic [15:0] c0;
  logic [3:0]  c1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int np0 = 0;
  int np1 = 0;
  int t_last = 0;
  int t_prev = 0;
  int m0 = 0;
  int m1 = 0;

  parity_check_rx #(
    .INPUT_WIDTH(8), .ODD_PARITY(1'b0), .ERR_CNT_WIDTH(16)
  ) u0 (
    .clock(clock), .reset(reset), .DigitSupply(supply),
    .serialIn(serialIn), .serialValid(serialValid),
    .syncClear(syncClear), .clearCount(clearCount),
    .outputData(d0), .outputValid(v0), .parityError(e0),
    .errorCount(c0), .busy(b0)
  );

  parity_check_rx #(
    .INPUT_WIDTH(8), .ODD_PARITY(1'b1), .ERR_CNT_WIDTH(4)
  ) u1 (
    .clock(clock), .reset(reset), .DigitSupply(supply),
    .serialIn(serialIn), .serialValid(serialValid),
    .syncClear(syncClear), .clearCount(clearCount),
    .outputData(d1), .outputValid(v1), .parityError(e1),
    .errorCount(c1), .busy(b1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (v0) begin
      np0++;
      t_prev = t_last;
      t_last = cyc;
    end
    if (v1) np1++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic p,
                      input int gap, input logic ee,
                      input logic eo, input logic clr);
    for (int i = 0; i < 8; i++) begin
      serialValid = 1'b1;
      serialIn = d[i];
      step();
      chk("busy_bit", {31'd0, b0}, 32'd1);
      if (gap > 0) begin
        serialValid = 1'b0;
        repeat ($urandom_range(gap, 0)) begin
          step();
          chk("busy_gap", {31'd0, b0}, 32'd1);
        end
      end
    end
    serialValid = 1'b1;
    serialIn = p;
    clearCount = clr;
    step();
    clearCount = 1'b0;
    if (ee && m0 != 65535) m0++;
    if (eo && m1 != 15) m1++;
    if (clr) begin
      m0 = 0;
      m1 = 0;
    end
    chk("data_even", {24'd0, d0}, {24'd0, d});
    chk("data_odd", {24'd0, d1}, {24'd0, d});
    chk("valid_even", {31'd0, v0}, 32'd1);
    chk("valid_odd", {31'd0, v1}, 32'd1);
    chk("perr_even", {31'd0, e0}, {31'd0, ee});
    chk("perr_odd", {31'd0, e1}, {31'd0, eo});
    chk("cnt_even", {16'd0, c0}, m0);
    chk("cnt_odd", {28'd0, c1}, m1);
    chk("busy_done", {31'd0, b0}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         gap;
    logic       ee;
    logic       eo;
  } vec_t;

  vec_t tbl[8];
  int   snap;
  int   snap1;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 0, 1'b0, 1'b1};
    tbl[1] = '{8'h07, 1'b0, 0, 1'b1, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 0, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 5, 1'b0, 1'b1};
    tbl[4] = '{8'hA5, 1'b1, 0, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 2, 1'b1, 1'b0};
    tbl[6] = '{8'h01, 1'b1, 0, 1'b0, 1'b1};
    tbl[7] = '{8'h5A, 1'b0, 3, 1'b0, 1'b1};

    repeat (2) step();
    chk("rst_data", {24'd0, d0}, 32'd0);
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_perr", {31'd0, e0}, 32'd0);
    chk("rst_cnt", {16'd0, c0}, 32'd0);
    chk("rst_busy", {31'd0, b0}, 32'd0);
    reset = 1'b0;
    step();

    for (int k = 0; k < 8; k++) begin
      send(tbl[k].d, tbl[k].p, tbl[k].gap, tbl[k].ee, tbl[k].eo, 1'b0);
      serialValid = 1'b0;
      step();
      chk("pulse_end", {31'd0, v0}, 32'd0);
      chk("hold_data", {24'd0, d0}, {24'd0, tbl[k].d});
      chk("hold_perr", {31'd0, e0}, {31'd0, tbl[k].ee});
    end

    // syncClear with a coincident valid bit mid-frame
    snap = np0;
    for (int i = 0; i < 5; i++) begin
      serialValid = 1'b1;
      serialIn = 1'b1;
      step();
    end
    syncClear = 1'b1;
    step();
    syncClear = 1'b0;
    serialValid = 1'b0;
    chk("sc_busy", {31'd0, b0}, 32'd0);
    chk("sc_data", {24'd0, d0}, 32'h5A);
    chk("sc_cnt", {16'd0, c0}, m0);
    send(8'h81, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    serialValid = 1'b0;
    step();
    chk("sc_pulses", np0 - snap, 32'd1);

    // syncClear on the parity edge drops the frame
    snap = np0;
    for (int i = 0; i < 8; i++) begin
      serialValid = 1'b1;
      serialIn = 1'b1;
      step();
    end
    serialIn = 1'b1;
    syncClear = 1'b1;
    step();
    syncClear = 1'b0;
    serialValid = 1'b0;
    step();
    chk("scp_pulses", np0 - snap, 32'd0);
    chk("scp_data", {24'd0, d0}, 32'h81);
    chk("scp_cnt", {16'd0, c0}, m0);

    // reset mid-frame
    snap = np0;
    for (int i = 0; i < 3; i++) begin
      serialValid = 1'b1;
      serialIn = 1'b1;
      step();
    end
    serialValid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_data", {24'd0, d0}, 32'd0);
    chk("mr_cnt", {16'd0, c0}, 32'd0);
    step();
    reset = 1'b0;
    m0 = 0;
    m1 = 0;
    repeat (3) step();
    chk("mr_busy", {31'd0, b0}, 32'd0);
    chk("mr_perr", {31'd0, e0}, 32'd0);
    chk("mr_cnt_odd", {28'd0, c1}, 32'd0);
    chk("mr_pulses", np0 - snap, 32'd0);

    // saturation on the 4-bit counter, back-to-back frames
    snap1 = np1;
    for (int k = 0; k < 17; k++) begin
      send(8'hA5, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    end
    chk("sat_cnt", {28'd0, c1}, 32'd15);
    send(8'hA5, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    serialValid = 1'b0;
    step();
    chk("clr_wins", {28'd0, c1}, 32'd0);
    chk("b2b_pulses", np1 - snap1, 32'd18);
    chk("b2b_spacing", t_last - t_prev, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
